ifstmt_operand_seq: RTL and testbench
=====================================

Name: ifstmt_operand_seq

Overview:
Upstream operand-sequencer stage that feeds the combinational add/multiply result stage.
- On a start request it emits a burst of NSTEPS (x, y) operand pairs over a valid/ready handshake.
- The seed pair is chosen by parameter Z; each new pair is Fibonacci-stepped from the previous one.
- It keeps a running checksum of the operation applied to every accepted pair, so the downstream result can be cross-checked.
- The block is built from constant-condition if/else and generate-if structures, so it doubles as a transformation-pass testcase.

Parameters:
- Z, 0: seed select. 0 gives seed x=4, y=3; any other value gives seed x=1, y=2.
- WIDTH, 32: operand and checksum width.
- NSTEPS, 8: pairs per burst. Legal range 1..255.
- OP_MUL, 0: checksum operation. 0 means x+y; 1 means x*y (product truncated to WIDTH).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  burst request; sampled only in IDLE.
- out_ready  in  1  downstream accepts the current pair.
- out_valid  out  1  x/y hold a valid pair.
- x  out  WIDTH  operand x.
- y  out  WIDTH  operand y.
- step  out  8  index of the current pair within the burst.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse after the last transfer.
- checksum  out  WIDTH  running sum of op(x, y) over accepted pairs.

Behaviour:
- Reset (async assert, sync release): state=IDLE; x, y, step, checksum = 0; out_valid, busy, done = 0. Asserting reset mid-burst drops out_valid immediately and abandons the burst with no done pulse.
- Transfer = out_valid && out_ready at a rising edge.
- IDLE:
  - start=1 at an edge loads the seed pair, clears step and checksum, and sets out_valid=1 and busy=1 from the next cycle. Next state is RUN.
  - Latency from start to first valid pair is 1 cycle.
- RUN, with a transfer:
  - checksum <= checksum + op(x, y), mod 2^WIDTH.
  - If step == NSTEPS-1: out_valid <= 0, go to DONE.
  - Otherwise: x <= x + y (mod 2^WIDTH), y <= x, step <= step + 1.
- RUN, no transfer (stall): x, y, step and checksum are held stable; out_valid stays 1.
- DONE: done=1 for exactly this cycle, busy=1, then IDLE. start is ignored in DONE; a new burst can begin from the following cycle.
- start is ignored in RUN.
- NSTEPS=1: exactly one transfer, then DONE.
- Arithmetic is unsigned; every intermediate result wraps at WIDTH bits.
- checksum holds its final value in IDLE until the next accepted start.

Optional Feature:
IFSTMT_OPERAND_SEQ_DISPLAY_EN
- Defined: a simulation-only always block $displays step, x and y on every transfer, and checksum in DONE.
- Undefined: no display code is compiled.
- Port-level behaviour is identical in both cases.

Decomposition:
- Package ifstmt_operand_seq_pkg holds:
  - state encoding as a 2-bit enum: IDLE=0, RUN=1, DONE=2;
  - seed constants SEED0_X=4, SEED0_Y=3, SEED1_X=1, SEED1_Y=2;
  - the STEP_W=8 constant.
- One sub-module, ifstmt_operand_op: purely combinational, with a generate-if on OP_MUL selecting x+y or x*y, truncated to WIDTH.
- The top level holds the FSM, operand registers and checksum register.

Test Plan:
- Z=0, NSTEPS=4, OP_MUL=0, out_ready=1, pulse start: pairs (4,3), (7,4), (11,7), (18,11) on consecutive cycles, step 0..3; checksum=65; done high for 1 cycle after the 4th transfer.
- Same bench with OP_MUL=1: checksum = 12+28+77+198 = 315.
- Z=1, NSTEPS=4, OP_MUL=0: pairs (1,2), (3,1), (4,3), (7,4); checksum=25.
- Backpressure: Z=0, out_ready low for 3 cycles after first valid: x=4, y=3, step=0, checksum=0 held stable for all 3 cycles; sequence resumes intact once out_ready rises.
- Wrap: WIDTH=4, Z=0, NSTEPS=4: 4th pair is (2,11); final checksum=1.
- Control robustness:
  - start pulsed mid-RUN and during DONE: no restart, pair sequence unchanged.
  - rst_n low after 2 transfers: all outputs 0 immediately.
  - New start after reset: restarts from (4,3) with checksum cleared.

Source files
------------

// File: rtl/ifstmt_operand_seq_pkg.sv
// Shared types and constants for the ifstmt_operand_seq operand sequencer.
package ifstmt_operand_seq_pkg;

  localparam int STEP_W  = 8;

  localparam int SEED0_X = 4;
  localparam int SEED0_Y = 3;
  localparam int SEED1_X = 1;
  localparam int SEED1_Y = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ifstmt_operand_seq_if.sv
// Burst control and operand stream between the sequencer (master) and its consumer (slave).
interface ifstmt_operand_seq_if #(
  parameter int WIDTH = 32
);
  import ifstmt_operand_seq_pkg::*;

  logic              start;
  logic              out_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  x;
  logic [WIDTH-1:0]  y;
  logic [STEP_W-1:0] step;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  checksum;

  modport master (
    input  start, out_ready,
    output out_valid, x, y, step, busy, done, checksum
  );

  modport slave (
    output start, out_ready,
    input  out_valid, x, y, step, busy, done, checksum
  );

endinterface

// File: rtl/ifstmt_operand_op.sv
// Combinational checksum operation: x+y or x*y, truncated to WIDTH.
module ifstmt_operand_op #(
  parameter int WIDTH  = 32,
  parameter int OP_MUL = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  generate
    if (OP_MUL != 0) begin : g_mul
      // Sized to WIDTH by the assignment context, so the upper product bits drop.
      assign result = a * b;
    end else begin : g_add
      assign result = a + b;
    end
  endgenerate

endmodule

// File: rtl/ifstmt_operand_seq.sv
// Operand sequencer: emits NSTEPS Fibonacci-stepped (x, y) pairs per start and
// accumulates a checksum of op(x, y). Optional macro: IFSTMT_OPERAND_SEQ_DISPLAY_EN.
module ifstmt_operand_seq
  import ifstmt_operand_seq_pkg::*;
#(
  parameter int Z      = 0,
  parameter int WIDTH  = 32,
  parameter int NSTEPS = 8,
  parameter int OP_MUL = 0
) (
  input  logic clk,
  input  logic rst_n,
  ifstmt_operand_seq_if.master bus
);

  state_t            state;
  logic [WIDTH-1:0]  x_q, y_q, checksum_q, op_result;
  logic [WIDTH-1:0]  seed_x, seed_y;
  logic [STEP_W-1:0] step_q;
  logic              valid_q, busy_q, done_q;
  logic              xfer, last_step;

  generate
    if (Z == 0) begin : g_seed0
      assign seed_x = WIDTH'(SEED0_X);
      assign seed_y = WIDTH'(SEED0_Y);
    end else begin : g_seed1
      assign seed_x = WIDTH'(SEED1_X);
      assign seed_y = WIDTH'(SEED1_Y);
    end
  endgenerate

  ifstmt_operand_op #(.WIDTH(WIDTH), .OP_MUL(OP_MUL)) u_op (
    .a      (x_q),
    .b      (y_q),
    .result (op_result)
  );

  assign xfer      = valid_q && bus.out_ready;
  assign last_step = (step_q == STEP_W'(NSTEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      step_q     <= '0;
      checksum_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so y_q <= x_q sees the pre-edge x_q.
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            x_q        <= seed_x;
            y_q        <= seed_y;
            step_q     <= '0;
            checksum_q <= '0;
            valid_q    <= 1'b1;
            busy_q     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            checksum_q <= checksum_q + op_result;
            if (last_step) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state   <= DONE;
            end else begin
              x_q    <= x_q + y_q;
              y_q    <= x_q;
              step_q <= step_q + STEP_W'(1);
            end
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.step      = step_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.checksum  = checksum_q;

`ifdef IFSTMT_OPERAND_SEQ_DISPLAY_EN
  always @(posedge clk) begin
    if (rst_n && state == RUN && xfer)
      $display("ifstmt_operand_seq: step=%0d x=%0d y=%0d", step_q, x_q, y_q);
    if (rst_n && state == DONE)
      $display("ifstmt_operand_seq: checksum=%0d", checksum_q);
  end
`else
`endif

endmodule

// File: tb/tb_ifstmt_operand_seq.sv
// Directed bench: five sequencer configurations run in lockstep from shared start/out_ready.
module tb_ifstmt_operand_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic ready;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ifstmt_operand_seq_if #(.WIDTH(32)) b_add ();
  ifstmt_operand_seq_if #(.WIDTH(32)) b_mul ();
  ifstmt_operand_seq_if #(.WIDTH(32)) b_z1  ();
  ifstmt_operand_seq_if #(.WIDTH(4))  b_w4  ();
  ifstmt_operand_seq_if #(.WIDTH(32)) b_n1  ();

  assign b_add.start = start;  assign b_add.out_ready = ready;
  assign b_mul.start = start;  assign b_mul.out_ready = ready;
  assign b_z1.start  = start;  assign b_z1.out_ready  = ready;
  assign b_w4.start  = start;  assign b_w4.out_ready  = ready;
  assign b_n1.start  = start;  assign b_n1.out_ready  = ready;

  ifstmt_operand_seq #(.Z(0), .WIDTH(32), .NSTEPS(4), .OP_MUL(0)) u_add (.clk(clk), .rst_n(rst_n), .bus(b_add));
  ifstmt_operand_seq #(.Z(0), .WIDTH(32), .NSTEPS(4), .OP_MUL(1)) u_mul (.clk(clk), .rst_n(rst_n), .bus(b_mul));
  ifstmt_operand_seq #(.Z(1), .WIDTH(32), .NSTEPS(4), .OP_MUL(0)) u_z1  (.clk(clk), .rst_n(rst_n), .bus(b_z1));
  ifstmt_operand_seq #(.Z(0), .WIDTH(4),  .NSTEPS(4), .OP_MUL(0)) u_w4  (.clk(clk), .rst_n(rst_n), .bus(b_w4));
  ifstmt_operand_seq #(.Z(0), .WIDTH(32), .NSTEPS(1), .OP_MUL(0)) u_n1  (.clk(clk), .rst_n(rst_n), .bus(b_n1));

  typedef struct {
    logic        start, ready;
    logic        valid;
    logic [31:0] x, y;
    logic [7:0]  step;
    logic        busy, done;
    logic [31:0] ck;
    logic [31:0] mul_ck;
    logic [31:0] z1_x, z1_y, z1_ck;
    logic [31:0] w4_x, w4_y, w4_ck;
    logic        n1_valid, n1_done;
    logic [31:0] n1_ck;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_add(input string tag, input logic v, input logic [31:0] ex, input logic [31:0] ey,
                           input logic [7:0] es, input logic eb, input logic ed, input logic [31:0] eck);
    check({tag, ".valid"},    32'(b_add.out_valid), 32'(v));
    check({tag, ".x"},        b_add.x, ex);
    check({tag, ".y"},        b_add.y, ey);
    check({tag, ".step"},     32'(b_add.step), 32'(es));
    check({tag, ".busy"},     32'(b_add.busy), 32'(eb));
    check({tag, ".done"},     32'(b_add.done), 32'(ed));
    check({tag, ".checksum"}, b_add.checksum, eck);
  endtask

  initial begin
    //             st ra  v  x   y  s  b  d  ck   mul   z1x z1y z1ck w4x w4y w4ck n1v n1d n1ck
    vecs[0] = '{1'b1, 1'b1, 1'b1,  4,  3, 0, 1'b1, 1'b0,  0,   0, 1, 2,  0,  4,  3, 0, 1'b1, 1'b0, 0};
    vecs[1] = '{1'b0, 1'b1, 1'b1,  7,  4, 1, 1'b1, 1'b0,  7,  12, 3, 1,  3,  7,  4, 7, 1'b0, 1'b1, 7};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 11,  7, 2, 1'b1, 1'b0, 18,  40, 4, 3,  7, 11,  7, 2, 1'b0, 1'b0, 7};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 18, 11, 3, 1'b1, 1'b0, 36, 117, 7, 4, 14,  2, 11, 4, 1'b0, 1'b0, 7};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 18, 11, 3, 1'b1, 1'b1, 65, 315, 7, 4, 25,  2, 11, 1, 1'b0, 1'b0, 7};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 18, 11, 3, 1'b0, 1'b0, 65, 315, 7, 4, 25,  2, 11, 1, 1'b0, 1'b0, 7};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 18, 11, 3, 1'b0, 1'b0, 65, 315, 7, 4, 25,  2, 11, 1, 1'b0, 1'b0, 7};

    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    cyc();
    cyc();
    check_add("reset", 1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
    #3 rst_n = 1'b1;
    cyc();

    // Lockstep burst across all configurations.
    for (int i = 0; i < 7; i++) begin
      string tag;
      tag   = $sformatf("vec%0d", i);
      start = vecs[i].start;
      ready = vecs[i].ready;
      cyc();
      check_add(tag, vecs[i].valid, vecs[i].x, vecs[i].y, vecs[i].step, vecs[i].busy, vecs[i].done, vecs[i].ck);
      check({tag, ".mul_ck"},   b_mul.checksum, vecs[i].mul_ck);
      check({tag, ".z1_x"},     b_z1.x, vecs[i].z1_x);
      check({tag, ".z1_y"},     b_z1.y, vecs[i].z1_y);
      check({tag, ".z1_ck"},    b_z1.checksum, vecs[i].z1_ck);
      check({tag, ".w4_x"},     32'(b_w4.x), vecs[i].w4_x);
      check({tag, ".w4_y"},     32'(b_w4.y), vecs[i].w4_y);
      check({tag, ".w4_ck"},    32'(b_w4.checksum), vecs[i].w4_ck);
      check({tag, ".n1_valid"}, 32'(b_n1.out_valid), 32'(vecs[i].n1_valid));
      check({tag, ".n1_done"},  32'(b_n1.done), 32'(vecs[i].n1_done));
      check({tag, ".n1_ck"},    b_n1.checksum, vecs[i].n1_ck);
    end

    // Backpressure: three stalled cycles after the first valid pair.
    start = 1'b1;
    ready = 1'b0;
    cyc();
    check_add("bp_first", 1'b1, 4, 3, 0, 1'b1, 1'b0, 0);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_add($sformatf("bp_stall%0d", i), 1'b1, 4, 3, 0, 1'b1, 1'b0, 0);
    end
    ready = 1'b1;
    cyc(); check_add("bp_r1",   1'b1,  7,  4, 1, 1'b1, 1'b0,  7);
    cyc(); check_add("bp_r2",   1'b1, 11,  7, 2, 1'b1, 1'b0, 18);
    cyc(); check_add("bp_r3",   1'b1, 18, 11, 3, 1'b1, 1'b0, 36);
    cyc(); check_add("bp_done", 1'b0, 18, 11, 3, 1'b1, 1'b1, 65);
    cyc(); check_add("bp_idle", 1'b0, 18, 11, 3, 1'b0, 1'b0, 65);

    // start held high through RUN and DONE must not restart the burst.
    start = 1'b1;
    cyc(); check_add("ctl_p0",   1'b1,  4,  3, 0, 1'b1, 1'b0,  0);
    cyc(); check_add("ctl_p1",   1'b1,  7,  4, 1, 1'b1, 1'b0,  7);
    cyc(); check_add("ctl_p2",   1'b1, 11,  7, 2, 1'b1, 1'b0, 18);
    cyc(); check_add("ctl_p3",   1'b1, 18, 11, 3, 1'b1, 1'b0, 36);
    cyc(); check_add("ctl_done", 1'b0, 18, 11, 3, 1'b1, 1'b1, 65);
    cyc(); check_add("ctl_idle", 1'b0, 18, 11, 3, 1'b0, 1'b0, 65);
    start = 1'b0;
    cyc(); check_add("ctl_hold", 1'b0, 18, 11, 3, 1'b0, 1'b0, 65);

    // Reset mid-burst after two transfers, then a clean restart.
    start = 1'b1;
    cyc(); check_add("rst_p0", 1'b1,  4, 3, 0, 1'b1, 1'b0,  0);
    start = 1'b0;
    cyc(); check_add("rst_p1", 1'b1,  7, 4, 1, 1'b1, 1'b0,  7);
    cyc(); check_add("rst_p2", 1'b1, 11, 7, 2, 1'b1, 1'b0, 18);
    #2 rst_n = 1'b0;
    #1 check_add("rst_async", 1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
    cyc();
    check_add("rst_held", 1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
    #3 rst_n = 1'b1;
    start = 1'b1;
    cyc(); check_add("rst_restart", 1'b1, 4, 3, 0, 1'b1, 1'b0, 0);
    start = 1'b0;
    cyc(); check_add("rst_next",    1'b1, 7, 4, 1, 1'b1, 1'b0, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
